// File: rtl/draw_pkg.sv
// Shared definitions for the draw command arbiter: FSM states, grant encoding
// and the packed command layout {col1, col2, row1, row2, color}, MSB first.
package draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  function automatic int cmd_width(input int cw, input int rw, input int colw);
    return 2 * cw + 2 * rw + colw;
  endfunction

  // LSB offset of each field inside the packed command
  function automatic int off_row2(input int colw);
    return colw;
  endfunction

  function automatic int off_row1(input int rw, input int colw);
    return colw + rw;
  endfunction

  function automatic int off_col2(input int rw, input int colw);
    return colw + 2 * rw;
  endfunction

  function automatic int off_col1(input int cw, input int rw, input int colw);
    return colw + 2 * rw + cw;
  endfunction

endpackage

// File: rtl/span_normalize.sv
// Orders one axis span so lo <= hi, then clamps both ends to the panel limit.
module span_normalize #(
  parameter int W     = 8,
  parameter int LIMIT = 239
) (
  input  logic [W-1:0] first,
  input  logic [W-1:0] second,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic [W-1:0] ord_lo;
  logic [W-1:0] ord_hi;

  always_comb begin
    ord_lo = first;
    ord_hi = second;
    if (first > second) begin
      ord_lo = second;
      ord_hi = first;
    end
    lo = (ord_lo > W'(LIMIT)) ? W'(LIMIT) : ord_lo;
    hi = (ord_hi > W'(LIMIT)) ? W'(LIMIT) : ord_hi;
  end

endmodule

// File: rtl/draw_cmd_arbiter.sv
// Two-requester draw command arbiter: alternates grants on ties, normalizes the
// accepted command, strobes it to the display and tracks ack/timeout/completion.
module draw_cmd_arbiter
  import draw_pkg::*;
#(
  parameter int COLOR_WIDTH = 3,
  parameter int NUM_COLS    = 240,
  parameter int NUM_ROWS    = 320,
  parameter int ACK_TIMEOUT = 16,
  localparam int CW         = $clog2(NUM_COLS),
  localparam int RW         = $clog2(NUM_ROWS),
  localparam int CMDW       = cmd_width(CW, RW, COLOR_WIDTH)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            a_valid_in,
  input  logic [CMDW-1:0] a_cmd_in,
  output logic            a_ready_out,
  input  logic            b_valid_in,
  input  logic [CMDW-1:0] b_cmd_in,
  output logic            b_ready_out,
  input  logic            disp_idle_in,
  output logic            disp_valid_out,
  output logic [CMDW-1:0] disp_cmd_out,
  output logic            busy_out,
  output logic [15:0]     issued_count_out,
  output logic [7:0]      timeout_count_out,
  output logic [1:0]      state_out
);

  localparam int TW     = $clog2(ACK_TIMEOUT + 1);
  localparam int O_COL1 = off_col1(CW, RW, COLOR_WIDTH);
  localparam int O_COL2 = off_col2(RW, COLOR_WIDTH);
  localparam int O_ROW1 = off_row1(RW, COLOR_WIDTH);
  localparam int O_ROW2 = off_row2(COLOR_WIDTH);

  state_t          state;
  logic            last_grant;
  logic [TW-1:0]   timer;
  logic            grant;
  logic            accept;
  logic [CMDW-1:0] sel_cmd;
  logic [CMDW-1:0] norm_cmd;
  logic [CW-1:0]   col_lo;
  logic [CW-1:0]   col_hi;
  logic [RW-1:0]   row_lo;
  logic [RW-1:0]   row_hi;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant = GRANT_A;
    if (a_valid_in && b_valid_in) begin
      grant = (last_grant == GRANT_B) ? GRANT_A : GRANT_B;
    end else if (b_valid_in) begin
      grant = GRANT_B;
    end
  end

  // Handshake: a requester's command transfers in the cycle where its valid and
  // ready are both high; ready is only offered in S_IDLE while the display is idle.
  assign accept      = rst_n_in && (state == S_IDLE) && disp_idle_in && (a_valid_in || b_valid_in);
  assign a_ready_out = accept && (grant == GRANT_A);
  assign b_ready_out = accept && (grant == GRANT_B);
  assign sel_cmd     = (grant == GRANT_B) ? b_cmd_in : a_cmd_in;

  span_normalize #(.W(CW), .LIMIT(NUM_COLS - 1)) u_col_norm (
    .first  (sel_cmd[O_COL1 +: CW]),
    .second (sel_cmd[O_COL2 +: CW]),
    .lo     (col_lo),
    .hi     (col_hi)
  );

  span_normalize #(.W(RW), .LIMIT(NUM_ROWS - 1)) u_row_norm (
    .first  (sel_cmd[O_ROW1 +: RW]),
    .second (sel_cmd[O_ROW2 +: RW]),
    .lo     (row_lo),
    .hi     (row_hi)
  );

  assign norm_cmd = {col_lo, col_hi, row_lo, row_hi, sel_cmd[COLOR_WIDTH-1:0]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= S_IDLE;
      last_grant        <= GRANT_B;
      timer             <= '0;
      disp_cmd_out      <= '0;
      issued_count_out  <= '0;
      timeout_count_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_ISSUE;
            last_grant   <= grant;
            disp_cmd_out <= norm_cmd;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_ACK;
          timer <= '0;
        end
        S_WAIT_ACK: begin
          // The display leaving idle wins over an expiring timer.
          if (!disp_idle_in) begin
            state <= S_WAIT_DONE;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            state <= S_IDLE;
            if (timeout_count_out != 8'hFF) begin
              timeout_count_out <= timeout_count_out + 8'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (disp_idle_in) begin
            state <= S_IDLE;
            if (issued_count_out != 16'hFFFF) begin
              issued_count_out <= issued_count_out + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign disp_valid_out = (state == S_ISSUE);
  assign busy_out       = (state != S_IDLE);
  assign state_out      = state;

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Bench for draw_cmd_arbiter: directed scenarios then random traffic, checked
// cycle by cycle against a timeline model of grants, strobes and counters.
module tb_draw_cmd_arbiter;

  localparam int CMDW = 37;
  localparam int MAXC = 239;
  localparam int MAXR = 319;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid;
  logic [CMDW-1:0] a_cmd;
  logic            a_ready;
  logic            b_valid;
  logic [CMDW-1:0] b_cmd;
  logic            b_ready;
  logic            disp_idle;
  logic            disp_valid;
  logic [CMDW-1:0] disp_cmd;
  logic            busy;
  logic [15:0]     issued_count;
  logic [7:0]      timeout_count;
  logic [1:0]      state;

  always #10 clk = ~clk;

  draw_cmd_arbiter dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .a_valid_in        (a_valid),
    .a_cmd_in          (a_cmd),
    .a_ready_out       (a_ready),
    .b_valid_in        (b_valid),
    .b_cmd_in          (b_cmd),
    .b_ready_out       (b_ready),
    .disp_idle_in      (disp_idle),
    .disp_valid_out    (disp_valid),
    .disp_cmd_out      (disp_cmd),
    .busy_out          (busy),
    .issued_count_out  (issued_count),
    .timeout_count_out (timeout_count),
    .state_out         (state)
  );

  int checks = 0;
  int errors = 0;

  // timeline model
  int cyc = 0;
  int idle_from, strobe_at, low_start, low_end, pend_kind;
  int exp_issued, exp_timeout, strobes;
  bit last_b, force_low;
  logic [CMDW-1:0] last_norm;
  logic [CMDW-1:0] exp_q[$];
  bit obs_log[$];

  // requesters and display plan
  bit a_pend, b_pend;
  logic [CMDW-1:0] a_pcmd, b_pcmd;
  bit plan_set, plan_to;
  int plan_d, plan_l;

  function automatic logic [CMDW-1:0] mk(input int c1, input int c2, input int r1,
                                         input int r2, input int color);
    return {8'(c1), 8'(c2), 9'(r1), 9'(r2), 3'(color)};
  endfunction

  function automatic int min2(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [CMDW-1:0] norm(input logic [CMDW-1:0] c);
    int c1, c2, r1, r2;
    c1 = int'(c[36:29]);
    c2 = int'(c[28:21]);
    r1 = int'(c[20:12]);
    r2 = int'(c[11:3]);
    return mk(min2(min2(c1, c2), MAXC), min2(max2(c1, c2), MAXC),
              min2(min2(r1, r2), MAXR), min2(max2(r1, r2), MAXR), int'(c[2:0]));
  endfunction

  function automatic logic [CMDW-1:0] rand_cmd();
    return mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511),
              $urandom_range(0, 511), $urandom_range(0, 7));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit keep_display);
    idle_from   = cyc;
    strobe_at   = -1;
    pend_kind   = 0;
    exp_issued  = 0;
    exp_timeout = 0;
    last_b      = 1'b1;
    last_norm   = '0;
    exp_q.delete();
    if (!keep_display) begin
      low_start = 0;
      low_end   = 0;
    end
  endtask

  task automatic step();
    bit di, arb_idle, exp_ra, exp_rb, to;
    int d, l;
    @(negedge clk);
    cyc++;
    di        = !force_low && !(cyc >= low_start && cyc < low_end);
    disp_idle = di;
    a_valid   = a_pend;
    a_cmd     = a_pcmd;
    b_valid   = b_pend;
    b_cmd     = b_pcmd;
    #1;
    arb_idle = (cyc >= idle_from);
    if (cyc == idle_from && pend_kind == 1) exp_issued++;
    if (cyc == idle_from && pend_kind == 2) exp_timeout++;
    if (cyc == idle_from) pend_kind = 0;
    exp_ra = 1'b0;
    exp_rb = 1'b0;
    if (arb_idle && di) begin
      if (a_pend && b_pend) begin
        if (last_b) exp_ra = 1'b1; else exp_rb = 1'b1;
      end else if (a_pend) exp_ra = 1'b1;
      else if (b_pend) exp_rb = 1'b1;
    end
    if (a_ready) obs_log.push_back(1'b0);
    if (b_ready) obs_log.push_back(1'b1);
    if (disp_valid) strobes++;
    chk("a_ready", a_ready, exp_ra);
    chk("b_ready", b_ready, exp_rb);
    chk("busy", busy, !arb_idle);
    chk("disp_valid", disp_valid, cyc == strobe_at);
    chk("disp_cmd_hold", disp_cmd, last_norm);
    chk("issued_count", issued_count, exp_issued);
    chk("timeout_count", timeout_count, exp_timeout);
    if (cyc == strobe_at && exp_q.size() > 0) chk("disp_cmd_strobe", disp_cmd, exp_q.pop_front());
    if (exp_ra || exp_rb) begin
      last_norm = norm(exp_ra ? a_pcmd : b_pcmd);
      exp_q.push_back(last_norm);
      last_b    = exp_rb;
      strobe_at = cyc + 1;
      if (exp_ra) a_pend = 1'b0; else b_pend = 1'b0;
      if (plan_set) begin
        to = plan_to; d = plan_d; l = plan_l;
      end else begin
        to = ($urandom_range(0, 5) == 0);
        d  = int'($urandom_range(0, 3));
        d  = (d == 3) ? 16 : d + 1;
        l  = int'($urandom_range(1, 6));
      end
      if (to) begin
        idle_from = cyc + 18;
        pend_kind = 2;
        low_start = 0;
        low_end   = 0;
      end else begin
        low_start = cyc + 1 + d;
        low_end   = low_start + l;
        idle_from = low_end + 1;
        pend_kind = 1;
      end
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input bit keep_display);
    #3 rst_n = 1'b0;
    #2;
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_disp_cmd", disp_cmd, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_issued", issued_count, 16'd0);
    chk("rst_timeout", timeout_count, 8'd0);
    #2 rst_n = 1'b1;
    model_reset(keep_display);
  endtask

  initial begin
    int busy_cycles;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_cmd = '0; b_cmd = '0; disp_idle = 1'b1;
    a_pend = 1'b0; b_pend = 1'b0; a_pcmd = '0; b_pcmd = '0;
    force_low = 1'b0; plan_set = 1'b0; plan_to = 1'b0; plan_d = 1; plan_l = 1;
    model_reset(1'b0);
    #15;
    chk("init_busy", busy, 1'b0);
    chk("init_disp_valid", disp_valid, 1'b0);
    chk("init_disp_cmd", disp_cmd, '0);
    chk("init_issued", issued_count, 16'd0);
    chk("init_timeout", timeout_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1'b0);

    // single A command, display leaves idle 2 cycles after the strobe for 50 cycles
    plan_set = 1'b1; plan_to = 1'b0; plan_d = 2; plan_l = 50;
    a_pcmd = mk(10, 20, 30, 40, 5); a_pend = 1'b1; strobes = 0;
    repeat (60) step();
    chk("req020_strobes", strobes, 1);
    chk("req020_issued", issued_count, 16'd1);
    chk("req020_cmd", disp_cmd, mk(10, 20, 30, 40, 5));

    // reversed and out-of-range spans
    plan_d = 1; plan_l = 1;
    a_pcmd = mk(250, 5, 400, 0, 2); a_pend = 1'b1;
    repeat (8) step();
    chk("req022_cmd", disp_cmd, mk(5, 239, 0, 319, 2));

    // display never leaves idle: timeout after 16 wait cycles
    plan_to = 1'b1;
    a_pcmd = rand_cmd(); a_pend = 1'b1; busy_cycles = 0;
    repeat (25) begin
      step();
      if (busy) busy_cycles++;
    end
    chk("req023_busy_cycles", busy_cycles, 17);
    chk("req023_timeout", timeout_count, 8'd1);
    chk("req023_issued", issued_count, 16'd2);

    // display busy while A waits: no ready, no strobe
    plan_to = 1'b0; plan_d = 1; plan_l = 1;
    force_low = 1'b1; a_pcmd = rand_cmd(); a_pend = 1'b1; strobes = 0;
    repeat (5) step();
    chk("req025_no_strobe", strobes, 0);
    force_low = 1'b0;
    repeat (6) step();
    chk("req025_strobe", strobes, 1);

    // both requesters continuously valid for four commands
    reset_pulse(1'b0);
    obs_log.delete();
    plan_d = 1; plan_l = 3;
    a_pcmd = rand_cmd(); a_pend = 1'b1;
    b_pcmd = rand_cmd(); b_pend = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!a_pend && (obs_log.size() + int'(b_pend) + 1 <= 4)) begin
        a_pcmd = rand_cmd(); a_pend = 1'b1;
      end
      if (!b_pend && (obs_log.size() + int'(a_pend) + 1 <= 4)) begin
        b_pcmd = rand_cmd(); b_pend = 1'b1;
      end
      step();
    end
    chk("req021_grants", obs_log.size(), 4);
    for (int i = 0; i < obs_log.size() && i < 4; i++)
      chk($sformatf("req021_grant%0d", i), obs_log[i], i % 2);
    chk("req021_issued", issued_count, 16'd4);

    // reset during S_WAIT_DONE with B pending
    plan_d = 1; plan_l = 40;
    a_pcmd = rand_cmd(); a_pend = 1'b1;
    step();
    b_pcmd = rand_cmd(); b_pend = 1'b1;
    repeat (3) step();
    reset_pulse(1'b1);
    plan_l = 2;
    obs_log.delete();
    repeat (50) step();
    chk("req024_b_granted", obs_log.size(), 1);
    chk("req024_issued", issued_count, 16'd1);

    // random traffic with random display behaviour
    plan_set = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_pcmd = rand_cmd(); a_pend = 1'b1;
      end
      if (!b_pend && $urandom_range(0, 2) == 0) begin
        b_pcmd = rand_cmd(); b_pend = 1'b1;
      end
      step();
    end
    repeat (80) step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
